// File: rtl/cp0_write_sched_pkg.sv
// Types shared by the CP0 write scheduler and its queue.
package cp0_write_sched_pkg;

  `include "cpu_defs.svh"

  // {reg[4:0], sel[2:0]}
  typedef logic [7:0] cp0_waddr_t;

  typedef struct packed {
    cp0_waddr_t addr;
    uint32_t    data;
  } cp0_wq_entry_t;

  function automatic cp0_waddr_t cp0_addr(input logic [4:0] rnum, input logic [2:0] sel);
    return {rnum, sel};
  endfunction

endpackage

// File: rtl/cp0_wq_fifo.sv
// Multi-push, single-pop queue of pending CP0 writes; storage is exposed for forwarding.
module cp0_wq_fifo
  import cp0_write_sched_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned IssueNum = 2,
  localparam int unsigned PtrW    = $clog2(Depth),
  localparam int unsigned CntW    = PtrW + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push_en_i,
  input  logic          [IssueNum-1:0]        push_valid_i,
  input  cp0_wq_entry_t [IssueNum-1:0]        push_entry_i,
  input  logic                                pop_i,
  output cp0_wq_entry_t                       head_o,
  output logic                                empty_o,
  output logic          [CntW-1:0]            count_o,
  output logic          [PtrW-1:0]            rd_ptr_o,
  output cp0_wq_entry_t [Depth-1:0]           mem_o,
  output logic          [Depth-1:0]           valid_o
);

  cp0_wq_entry_t [Depth-1:0] mem_q;
  logic [Depth-1:0]          valid_q, valid_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [CntW-1:0]           n_enq;
  logic [IssueNum-1:0]       wen;
  logic [IssueNum-1:0][PtrW-1:0] widx;
  logic                      pop_eff;

  assign pop_eff = pop_i && (count_q != '0);

  // Valid slots are packed into consecutive entries starting at wr_ptr, slot 0 first.
  always_comb begin
    n_enq = '0;
    wen   = '0;
    widx  = '0;
    for (int s = 0; s < int'(IssueNum); s++) begin
      if (push_en_i && push_valid_i[s]) begin
        wen[s]  = 1'b1;
        widx[s] = wr_ptr_q + n_enq[PtrW-1:0];
        n_enq   = n_enq + CntW'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + n_enq[PtrW-1:0];
    rd_ptr_d = rd_ptr_q + PtrW'(pop_eff);
    count_d  = count_q + n_enq - CntW'(pop_eff);
    valid_d  = valid_q;
    if (pop_eff) valid_d[rd_ptr_q] = 1'b0;
    for (int s = 0; s < int'(IssueNum); s++) begin
      if (wen[s]) valid_d[widx[s]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload needs no reset; valid_q qualifies every use.
  always_ff @(posedge clk) begin
    for (int s = 0; s < int'(IssueNum); s++) begin
      if (wen[s]) mem_q[widx[s]] <= push_entry_i[s];
    end
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rd_ptr_o = rd_ptr_q;
  assign mem_o    = mem_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/cpu_defs.svh
// Shared CPU-wide definitions: issue width and basic scalar types.
`ifndef CPU_DEFS_SVH
`define CPU_DEFS_SVH

`define ISSUE_NUM 2

typedef logic [31:0] uint32_t;

`endif

// File: rtl/cp0_write_sched.sv
// Buffers MM-stage CP0 writes, drains them one per cycle and forwards pending data to mfc0.
`include "cpu_defs.svh"

module cp0_write_sched
  import cp0_write_sched_pkg::*;
#(
  parameter int unsigned ISSUE_NUM = `ISSUE_NUM,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned PtrW     = $clog2(DEPTH),
  localparam int unsigned CntW     = PtrW + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic    [ISSUE_NUM-1:0]        wr_valid_i,
  input  logic    [ISSUE_NUM-1:0][7:0]   wr_addr_i,
  input  uint32_t [ISSUE_NUM-1:0]        wr_data_i,
  input  logic                           flush_i,
  output logic                           stall_o,
  output logic                           cp0_we_o,
  output logic    [7:0]                  cp0_waddr_o,
  output uint32_t                        cp0_wdata_o,
  input  logic    [7:0]                  rd_addr_i,
  input  uint32_t                        rd_data_i,
  output uint32_t                        rd_data_o,
  output logic    [CntW-1:0]             count_o,
  output logic                           empty_o
);

  cp0_wq_entry_t [ISSUE_NUM-1:0] push_entry;
  cp0_wq_entry_t                 head;
  cp0_wq_entry_t [DEPTH-1:0]     q_mem;
  logic          [DEPTH-1:0]     q_valid;
  logic          [PtrW-1:0]      q_rd_ptr;
  logic          [PtrW-1:0]      fwd_idx;
  logic          [CntW-1:0]      q_count;
  logic                          q_empty;
  logic                          ready;
  logic                          accept;

  always_comb begin
    for (int s = 0; s < int'(ISSUE_NUM); s++) begin
      push_entry[s].addr = wr_addr_i[s];
      push_entry[s].data = wr_data_i[s];
    end
  end

  // Space check uses the registered count only; a same-cycle pop does not help.
  assign ready   = (int'(DEPTH) - int'(q_count)) >= int'(ISSUE_NUM);
  assign accept  = ready && !flush_i && !rst;
  assign stall_o = (|wr_valid_i) && !ready && !flush_i && !rst;

  assign cp0_we_o    = !q_empty && !rst;
  assign cp0_waddr_o = head.addr;
  assign cp0_wdata_o = head.data;
  assign count_o     = rst ? '0 : q_count;
  assign empty_o     = q_empty || rst;

  cp0_wq_fifo #(
    .Depth    (DEPTH),
    .IssueNum (ISSUE_NUM)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_en_i    (accept),
    .push_valid_i (wr_valid_i),
    .push_entry_i (push_entry),
    .pop_i        (cp0_we_o),
    .head_o       (head),
    .empty_o      (q_empty),
    .count_o      (q_count),
    .rd_ptr_o     (q_rd_ptr),
    .mem_o        (q_mem),
    .valid_o      (q_valid)
  );

  // Scan oldest to youngest so later hits win; the popping head still counts.
  always_comb begin
    rd_data_o = rd_data_i;
    fwd_idx   = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      fwd_idx = q_rd_ptr + PtrW'(k);
      if (q_valid[fwd_idx] && (q_mem[fwd_idx].addr == rd_addr_i)) begin
        rd_data_o = q_mem[fwd_idx].data;
      end
    end
    for (int s = 0; s < int'(ISSUE_NUM); s++) begin
      if (accept && wr_valid_i[s] && (wr_addr_i[s] == rd_addr_i)) begin
        rd_data_o = wr_data_i[s];
      end
    end
    if (rst) rd_data_o = rd_data_i;
  end

endmodule

// File: tb/tb_cp0_write_sched.sv
// Directed checks of the CP0 write scheduler: ordering, forwarding, stall, flush, wrap, reset.
module tb_cp0_write_sched;
  localparam int ISSUE_NUM = 2;
  localparam int DEPTH     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       wr_valid;
  logic [1:0][7:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             flush;
  logic             stall;
  logic             cp0_we;
  logic [7:0]       cp0_waddr;
  logic [31:0]      cp0_wdata;
  logic [7:0]       rd_addr;
  logic [31:0]      rd_data_in;
  logic [31:0]      rd_data_out;
  logic [2:0]       count;
  logic             empty;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] log_q[$];

  cp0_write_sched #(
    .ISSUE_NUM (ISSUE_NUM),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid_i  (wr_valid),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .flush_i     (flush),
    .stall_o     (stall),
    .cp0_we_o    (cp0_we),
    .cp0_waddr_o (cp0_waddr),
    .cp0_wdata_o (cp0_wdata),
    .rd_addr_i   (rd_addr),
    .rd_data_i   (rd_data_in),
    .rd_data_o   (rd_data_out),
    .count_o     (count),
    .empty_o     (empty)
  );

  always #5 clk = ~clk;

  // Record every CP0 write once per cycle, away from the active edge.
  always @(negedge clk) if (cp0_we === 1'b1) log_q.push_back(cp0_wdata);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 2'b00;
    flush    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && empty !== 1'b1; i++) step();
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_timeout: empty=%b want 1", empty); end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    wr_valid = 2'b11; wr_addr[0] = 8'h60; wr_addr[1] = 8'h68;
    wr_data[0] = 32'h1111; wr_data[1] = 32'h2222;
    rd_addr = 8'h60; rd_data_in = 32'hCAFE_0001;
    step(); step();
    n_cmp++; if (cp0_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", cp0_we); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (rd_data_out !== 32'hCAFE_0001) begin n_fail++; $display("FAIL rst_rd: got %h want cafe0001", rd_data_out); end
    idle();
    rst = 1'b0;
    step();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL post_rst_count: got %0d want 0", count); end
  endtask

  task automatic test_in_order();
    wr_valid = 2'b11;
    wr_addr[0] = cp0_write_sched_pkg::cp0_addr(5'd12, 3'd0); wr_data[0] = 32'h1;
    wr_addr[1] = cp0_write_sched_pkg::cp0_addr(5'd13, 3'd0); wr_data[1] = 32'h2;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ord_stall: got %b want 0", stall); end
    n_cmp++; if (cp0_we !== 1'b0) begin n_fail++; $display("FAIL ord_we_c0: got %b want 0", cp0_we); end
    step(); idle(); #1;
    n_cmp++; if (cp0_we !== 1'b1 || cp0_waddr !== 8'h60 || cp0_wdata !== 32'h1) begin
      n_fail++; $display("FAIL ord_c1: got we=%b a=%h d=%h want 1 60 1", cp0_we, cp0_waddr, cp0_wdata); end
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL ord_cnt_c1: got %0d want 2", count); end
    step();
    n_cmp++; if (cp0_we !== 1'b1 || cp0_waddr !== 8'h68 || cp0_wdata !== 32'h2) begin
      n_fail++; $display("FAIL ord_c2: got we=%b a=%h d=%h want 1 68 2", cp0_we, cp0_waddr, cp0_wdata); end
    step();
    n_cmp++; if (empty !== 1'b1 || cp0_we !== 1'b0) begin
      n_fail++; $display("FAIL ord_c3: got empty=%b we=%b want 1 0", empty, cp0_we); end
  endtask

  task automatic test_same_addr_fwd();
    log_q.delete();
    wr_valid = 2'b11; wr_addr[0] = 8'h60; wr_addr[1] = 8'h60;
    wr_data[0] = 32'hA; wr_data[1] = 32'hB;
    rd_addr = 8'h60; rd_data_in = 32'hDEAD;
    #1;
    n_cmp++; if (rd_data_out !== 32'hB) begin n_fail++; $display("FAIL fwd_incoming: got %h want b", rd_data_out); end
    step(); idle(); #1;
    n_cmp++; if (rd_data_out !== 32'hB) begin n_fail++; $display("FAIL fwd_youngest: got %h want b", rd_data_out); end
    n_cmp++; if (cp0_wdata !== 32'hA) begin n_fail++; $display("FAIL fwd_drain0: got %h want a", cp0_wdata); end
    step();
    n_cmp++; if (rd_data_out !== 32'hB) begin n_fail++; $display("FAIL fwd_head_pop: got %h want b", rd_data_out); end
    n_cmp++; if (cp0_wdata !== 32'hB) begin n_fail++; $display("FAIL fwd_drain1: got %h want b", cp0_wdata); end
    step();
    n_cmp++; if (rd_data_out !== 32'hDEAD) begin n_fail++; $display("FAIL fwd_raw: got %h want dead", rd_data_out); end
    n_cmp++; if (log_q.size() != 2 || log_q[0] !== 32'hA || log_q[1] !== 32'hB) begin
      n_fail++; $display("FAIL fwd_log: got %0d writes want 2 (a,b)", log_q.size()); end
  endtask

  task automatic test_fwd_priority();
    rd_addr = 8'h78; rd_data_in = 32'h9999;
    wr_valid = 2'b11; wr_addr[0] = 8'h78; wr_data[0] = 32'h111; wr_addr[1] = 8'h60; wr_data[1] = 32'h222;
    #1;
    n_cmp++; if (rd_data_out !== 32'h111) begin n_fail++; $display("FAIL pri_slot0: got %h want 111", rd_data_out); end
    step();
    wr_addr[0] = 8'h78; wr_data[0] = 32'h333; wr_addr[1] = 8'h80; wr_data[1] = 32'h444;
    #1;
    n_cmp++; if (rd_data_out !== 32'h333) begin n_fail++; $display("FAIL pri_in_over_q: got %h want 333", rd_data_out); end
    step(); idle(); #1;
    n_cmp++; if (rd_data_out !== 32'h333) begin n_fail++; $display("FAIL pri_queued: got %h want 333", rd_data_out); end
    n_cmp++; if (cp0_wdata !== 32'h222) begin n_fail++; $display("FAIL pri_head: got %h want 222", cp0_wdata); end
    drain();
  endtask

  task automatic test_stall();
    log_q.delete();
    rd_data_in = 32'h5555; rd_addr = 8'h31;
    wr_valid = 2'b11; wr_addr[0] = 8'h11; wr_data[0] = 32'h11; wr_addr[1] = 8'h12; wr_data[1] = 32'h12;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_c1: got %b want 0", stall); end
    step();
    wr_addr[0] = 8'h21; wr_data[0] = 32'h21; wr_addr[1] = 8'h22; wr_data[1] = 32'h22;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_c2: got %b want 0", stall); end
    step();
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL stall_fill: got %0d want 3", count); end
    wr_addr[0] = 8'h31; wr_data[0] = 32'h31; wr_addr[1] = 8'h32; wr_data[1] = 32'h32;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_full: got %b want 1", stall); end
    n_cmp++; if (rd_data_out !== 32'h5555) begin n_fail++; $display("FAIL stall_no_fwd: got %h want 5555", rd_data_out); end
    step(); #1;
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL stall_noenq: got %0d want 2", count); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", stall); end
    n_cmp++; if (rd_data_out !== 32'h31) begin n_fail++; $display("FAIL stall_fwd_acc: got %h want 31", rd_data_out); end
    step(); idle();
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL stall_accept: got %0d want 3", count); end
    drain();
    n_cmp++; if (log_q.size() != 6 || log_q[0] !== 32'h11 || log_q[1] !== 32'h12 || log_q[2] !== 32'h21 ||
                 log_q[3] !== 32'h22 || log_q[4] !== 32'h31 || log_q[5] !== 32'h32) begin
      n_fail++; $display("FAIL stall_order: got %0d writes want 6 (11,12,21,22,31,32)", log_q.size()); end
  endtask

  task automatic test_flush();
    log_q.delete();
    wr_valid = 2'b11; wr_addr[0] = 8'h41; wr_data[0] = 32'h41; wr_addr[1] = 8'h42; wr_data[1] = 32'h42;
    step();
    wr_valid = 2'b01; wr_addr[0] = 8'h70; wr_data[0] = 32'h5; flush = 1'b1;
    rd_addr = 8'h70; rd_data_in = 32'h1234;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
    n_cmp++; if (rd_data_out !== 32'h1234) begin n_fail++; $display("FAIL flush_rd: got %h want 1234", rd_data_out); end
    step(); idle(); #1;
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", count); end
    drain();
    n_cmp++; if (log_q.size() != 2 || log_q[0] !== 32'h41 || log_q[1] !== 32'h42) begin
      n_fail++; $display("FAIL flush_drain: got %0d writes want 2 (41,42)", log_q.size()); end
  endtask

  task automatic test_wrap();
    logic [1:0]  masks [4];
    logic [31:0] exp_q[$];
    int          next;
    int          mcount;
    int          k;
    logic        mready;
    masks[0] = 2'b11; masks[1] = 2'b10; masks[2] = 2'b01; masks[3] = 2'b11;
    log_q.delete();
    next = 0; mcount = 0;
    for (int cyc = 0; cyc < 200 && next < 12; cyc++) begin
      k = 0; wr_valid = 2'b00;
      for (int s = 0; s < 2; s++) begin
        if (masks[cyc % 4][s] && next + k < 12) begin
          wr_valid[s] = 1'b1; wr_addr[s] = 8'(next + k); wr_data[s] = 32'h100 + 32'(next + k); k++;
        end
      end
      #1;
      mready = (DEPTH - mcount) >= ISSUE_NUM;
      n_cmp++; if (stall !== ((|wr_valid) && !mready)) begin
        n_fail++; $display("FAIL wrap_stall: cyc %0d got %b want %b", cyc, stall, (|wr_valid) && !mready); end
      if (mready) begin
        for (int s = 0; s < 2; s++) if (wr_valid[s]) exp_q.push_back(wr_data[s]);
        next += k;
      end
      step();
      mcount = mcount + (mready ? k : 0) - (mcount > 0 ? 1 : 0);
      n_cmp++; if (count !== 3'(mcount)) begin
        n_fail++; $display("FAIL wrap_count: cyc %0d got %0d want %0d", cyc, count, mcount); end
    end
    idle();
    drain();
    n_cmp++; if (log_q.size() != 12) begin n_fail++; $display("FAIL wrap_nwrites: got %0d want 12", log_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, (i < log_q.size()) ? log_q[i] : 32'hx, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    wr_valid = 2'b11; wr_addr[0] = 8'h01; wr_data[0] = 32'hA1; wr_addr[1] = 8'h02; wr_data[1] = 32'hA2;
    step();
    wr_data[0] = 32'hA3; wr_data[1] = 32'hA4;
    step(); idle();
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL rmid_fill: got %0d want 3", count); end
    log_q.delete();
    rst = 1'b1;
    #1;
    n_cmp++; if (cp0_we !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL rmid_during: got we=%b empty=%b want 0 1", cp0_we, empty); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (cp0_we !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL rmid_after: got we=%b cnt=%0d empty=%b want 0 0 1", cp0_we, count, empty); end
    step();
    n_cmp++; if (log_q.size() != 0 || cp0_we !== 1'b0) begin
      n_fail++; $display("FAIL rmid_nowrite: got %0d writes we=%b want 0 0", log_q.size(), cp0_we); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_in_order();
    test_same_addr_fwd();
    test_fwd_priority();
    test_stall();
    test_flush();
    test_wrap();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_write_sched.md
CP0_WRITE_SCHED -- requirements
Module: cp0_write_sched

Interface
REQ-001 SHALL have parameter ISSUE_NUM, default `ISSUE_NUM (2): number of issue slots presenting CP0 writes per cycle.
REQ-002 SHALL have parameter DEPTH, default 4: write-queue entries; power of 2 and >= ISSUE_NUM.
REQ-003 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid_i  in  [ISSUE_NUM]  per-slot CP0 write request from the MM stage; slot 0 is the oldest.
REQ-006 SHALL have port wr_addr_i  in  [ISSUE_NUM][8]  per-slot target, {reg[4:0], sel[2:0]}.
REQ-007 SHALL have port wr_data_i  in  [ISSUE_NUM] uint32_t  per-slot write data.
REQ-008 SHALL have port flush_i  in  1  squashes this cycle's incoming requests only.
REQ-009 SHALL have port stall_o  out  1  any un-squashed wr_valid_i while not ready; the pipeline holds MM.
REQ-010 SHALL have port cp0_we_o / cp0_waddr_o[8] / cp0_wdata_o uint32_t  out  single CP0 register-file write port.
REQ-011 SHALL have port rd_addr_i  in  [8]  mfc0 read address.
REQ-012 SHALL have port rd_data_i  in  uint32_t  raw CP0 register-file read data.
REQ-013 SHALL have port rd_data_o  out  uint32_t  forwarded read data.
REQ-014 SHALL have port count_o  out  [$clog2(DEPTH)+1]  occupied entries.
REQ-015 SHALL have port empty_o  out  1  count_o == 0.

Function
REQ-016 SHALL compute ready = (DEPTH - count) >= ISSUE_NUM from the registered count, ignoring any same-cycle pop.
REQ-017 SHALL accept requests when ready and !flush_i, enqueueing all valid slots in one cycle, slot 0 first.
REQ-018 SHALL skip invalid slots, so entries stay packed.
REQ-019 SHALL drive stall_o = |wr_valid_i & !ready & !flush_i, and SHALL enqueue nothing while stalled.
REQ-020 SHALL present the head entry combinationally whenever the queue is non-empty, with cp0_we_o = !empty.
REQ-021 SHALL pop the head every cycle that cp0_we_o is 1; the drain rate is one write per cycle.
REQ-022 SHALL write an entry enqueued in cycle N to CP0 no earlier than cycle N+1.
REQ-023 SHALL write entries to CP0 strictly in enqueue order.
REQ-024 SHALL allow enqueue and pop in the same cycle: count_next = count + n_enq - pop.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL never let count exceed DEPTH.
REQ-027 SHALL resolve rd_data_o by priority, highest first:
  - the highest-index accepted incoming slot matching rd_addr_i;
  - else the youngest queued entry matching rd_addr_i;
  - else rd_data_i.
REQ-028 SHALL exclude squashed or stalled incoming slots from forwarding.
REQ-029 SHALL let the head entry being popped this cycle still forward, since the regfile is not yet updated.
REQ-030 SHALL leave already-queued entries unaffected by flush_i (they are committed).

Reset
REQ-031 SHALL on rst clear the pointers, count_o and all entry valid bits.
REQ-032 SHALL hold these outputs while rst is high: cp0_we_o=0, empty_o=1, stall_o=0, rd_data_o=rd_data_i.
REQ-033 SHALL discard queued writes when rst asserts mid-drain, with no CP0 write in the cycle after rst.

Structure
REQ-034 SHALL take ISSUE_NUM and uint32_t from cpu_defs.svh.
REQ-035 SHALL define a cp0_waddr_t (8-bit) typedef and a cp0_wq_entry_t struct {addr, data} in the shared package.
REQ-036 SHALL implement the queue storage and pointers as one sub-module, cp0_wq_fifo (multi-push, single-pop).
REQ-037 SHALL implement forwarding and ready/stall logic combinationally in the top module.

Verification
REQ-038 SHALL cover: reset, then slot0 {12,0}=0x1, slot1 {13,0}=0x2 in cycle 0 -> cycle 1 cp0 write {12,0}=0x1, cycle 2 {13,0}=0x2, cycle 3 empty_o=1.
REQ-039 SHALL cover: both slots write {12,0} (0xA, then 0xB) with rd_addr_i={12,0} in the same cycle -> rd_data_o=0xB; queue later drains 0xA then 0xB.
REQ-040 SHALL cover: fill to count=3 with DEPTH=4, then a 2-slot request -> stall_o=1 and nothing enqueued; after one pop (count=2) the request is accepted and stall_o=0.
REQ-041 SHALL cover: flush_i=1 with slot0 valid {14,0}=0x5 -> count_o unchanged, rd_data_o=rd_data_i, queued entries still drain.
REQ-042 SHALL cover: 12 writes streamed through DEPTH=4 -> pointer wrap; CP0 write order and data match a scoreboard exactly.
REQ-043 SHALL cover: rst asserted while count=3 -> next cycle cp0_we_o=0, count_o=0, empty_o=1.
